klp32_lsu: RTL and testbench
============================

// Module: klp32_lsu
// PURPOSE
//  Load/store unit between KLP32V1 execute stage (ALU address, memRW, funct3) and a
//  handshaked synchronous data memory. Generates byte enables and store lane steering,
//  sign/zero-extends load data, and stalls the core until the response returns.
//  Replaces the core's combinational data-memory read with a multi-cycle bus access.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in ACCESS without i_mem_ack before bus error (>=2)
// PORTS
//  clk            in   1   system clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  i_req_valid    in   1   core presents load/store this cycle
//  o_req_ready    out  1   LSU can accept a request (state==IDLE)
//  i_we           in   1   1=store, 0=load (memRW)
//  i_funct3       in   3   RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_addr         in   32  byte address (ALU out)
//  i_wdata        in   32  store data (rs2)
//  o_stall        out  1   hold PC/regfile write while high
//  o_resp_valid   out  1   one-cycle pulse: o_rdata/o_bus_err/o_misaligned valid
//  o_rdata        out  32  extended load data (0 for stores and errors)
//  o_bus_err      out  1   timeout or illegal funct3, valid with o_resp_valid
//  o_misaligned   out  1   misaligned access flag, valid with o_resp_valid
//  o_mem_req      out  1   memory request, held until ack
//  o_mem_we       out  1   memory write enable
//  o_mem_addr     out  30  word address (addr[31:2])
//  o_mem_be       out  4   byte enables
//  o_mem_wdata    out  32  lane-steered store data
//  i_mem_ack      in   1   memory completes access this cycle
//  i_mem_rdata    in   32  read word, valid with i_mem_ack
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except o_req_ready=1; timeout counter 0.
//  FSM IDLE->ACCESS->RESP->IDLE; IDLE->RESP directly for illegal funct3/misaligned trap.
//  IDLE: on i_req_valid capture addr/we/funct3/be/wdata; o_stall=i_req_valid.
//  ACCESS: o_mem_req=1, o_stall=1; mem outputs stable from registers; count cycles.
//   i_mem_ack: capture extended data, ->RESP. Count reaches TIMEOUT_CYCLES-1
//   with no ack: ->RESP, o_bus_err=1, o_rdata=0. Ack on timeout cycle: ack wins.
//  RESP: o_resp_valid=1, o_stall=0 (core commits), o_req_ready=0; next ->IDLE.
//  Min latency: request edge N, ack in N+1, o_resp_valid in N+2; new request at N+3.
//  Byte enables: B 0001<<a[1:0]; H 0011<<{a[1],1'b0}; W 1111.
//  Store data: B replicated x4, H replicated x2, W as-is.
//  Load: select lane by a[1:0]; B/H sign-extend, BU/HU zero-extend, W passthrough.
//  funct3 011/110/111: no memory access, ->RESP with o_bus_err=1.
//  Store completion: o_rdata=0.
//  Reset mid-ACCESS: o_mem_req drops asynchronously; in-flight ack ignored.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with a[0]=1 or W with a[1:0]!=0 skips memory,
//   ->RESP with o_misaligned=1, o_rdata=0.
//  Not defined: offending low address bits forced to 0 (aligned access);
//   o_misaligned tied 0.
// STRUCTURE
//  klp32_pkg: lsu_width_e (funct3 codes), lsu_state_e {IDLE,ACCESS,RESP}.
//  Sub-module klp32_lsu_align: combinational be/wdata steering and load extension;
//   FSM, counter and capture registers stay in klp32_lsu.
// TESTING
//  SW 0xDEADBEEF @0x100, ack after 1 cycle -> be=1111, mem_addr=0x40, resp in 3 cycles.
//  SB 0x000000A5 @0x103 -> be=1000, mem_wdata=0xA5A5A5A5; LB @0x103 with
//   rdata=0xA5000000 -> o_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
//  LH @0x102, rdata=0x80010000 -> 0xFFFF8001; LHU -> 0x00008001.
//  No ack, TIMEOUT_CYCLES=4 -> o_bus_err=1, o_rdata=0 on resp; next request accepted.
//  LW @0x101: with MISALIGN_TRAP_EN o_misaligned=1, o_mem_req never high;
//   without: access at mem_addr=0x40, be=1111.
//  reset low mid-ACCESS -> o_mem_req=0 and o_stall=0 immediately; funct3=011 -> bus_err.

Source files
------------

// File: rtl/klp32_pkg.sv
// Shared types for the KLP32V1 load/store unit: RV32I load/store width codes and LSU FSM states.
package klp32_pkg;

  typedef enum logic [2:0] {
    LSU_B  = 3'b000,
    LSU_H  = 3'b001,
    LSU_W  = 3'b010,
    LSU_BU = 3'b100,
    LSU_HU = 3'b101
  } lsu_width_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // 011, 110 and 111 have no RV32I load/store meaning and never reach memory.
  function automatic logic isLegalWidth(input logic [2:0] funct3);
    return (funct3 == LSU_B)  || (funct3 == LSU_H)  || (funct3 == LSU_W) ||
           (funct3 == LSU_BU) || (funct3 == LSU_HU);
  endfunction

endpackage

// File: rtl/klp32_lsu_align.sv
// Combinational lane logic for klp32_lsu: store byte enables and data replication,
// plus load lane selection with sign or zero extension.
module klp32_lsu_align
  import klp32_pkg::*;
(
  input  logic [2:0]  reqFunct3,
  input  logic [1:0]  reqOff,
  input  logic [31:0] reqWdata,
  output logic [3:0]  memBe,
  output logic [31:0] memWdata,
  input  logic [2:0]  rspFunct3,
  input  logic [1:0]  rspOff,
  input  logic [31:0] memRdata,
  output logic [31:0] loadData
);

  logic        [31:0] laneWord;
  logic signed [7:0]  laneByte;
  logic signed [15:0] laneHalf;

  always_comb begin
    memBe    = 4'b1111;
    memWdata = reqWdata;
    case (reqFunct3[1:0])
      2'b00: begin
        memBe    = 4'b0001 << reqOff;
        memWdata = {4{reqWdata[7:0]}};
      end
      2'b01: begin
        memBe    = 4'b0011 << {reqOff[1], 1'b0};
        memWdata = {2{reqWdata[15:0]}};
      end
      default: ;
    endcase
  end

  // The offset is already aligned to the access size, so the wanted lane lands at bit 0.
  always_comb begin
    laneWord = memRdata >> {rspOff, 3'b000};
    laneByte = laneWord[7:0];
    laneHalf = laneWord[15:0];
    case (rspFunct3)
      LSU_B:   loadData = 32'(laneByte);
      LSU_H:   loadData = 32'(laneHalf);
      LSU_BU:  loadData = {24'd0, laneWord[7:0]};
      LSU_HU:  loadData = {16'd0, laneWord[15:0]};
      default: loadData = memRdata;
    endcase
  end

endmodule

// File: rtl/klp32_lsu.sv
// KLP32V1 load/store unit: stalls the core across a handshaked data-memory access.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of force-aligning them.
module klp32_lsu
  import klp32_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_resp_valid,
  output logic [31:0] o_rdata,
  output logic        o_bus_err,
  output logic        o_misaligned,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [29:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CntW = $clog2(TIMEOUT_CYCLES);

  lsu_state_e       state;
  logic [CntW-1:0]  cnt;
  logic             weQ;
  logic [2:0]       funct3Q;
  logic [1:0]       offQ;
  logic [29:0]      addrQ;
  logic [3:0]       beQ;
  logic [31:0]      wdataQ;
  logic [31:0]      rdataQ;
  logic             busErrQ;
  logic             isHalf;
  logic             isWord;
  logic [1:0]       reqOff;
  logic [3:0]       reqBe;
  logic [31:0]      reqWdata;
  logic [31:0]      loadData;

  assign isHalf = (i_funct3[1:0] == 2'b01);
  assign isWord = (i_funct3 == LSU_W);

`ifdef MISALIGN_TRAP_EN
  logic misalignReq;
  logic misalignQ;
  assign misalignReq  = (isHalf && i_addr[0]) || (isWord && (i_addr[1:0] != 2'b00));
  assign reqOff       = i_addr[1:0];
  assign o_misaligned = misalignQ;
`else
  assign reqOff       = isWord ? 2'b00 : (isHalf ? {i_addr[1], 1'b0} : i_addr[1:0]);
  assign o_misaligned = 1'b0;
`endif

  klp32_lsu_align uAlign (
    .reqFunct3 (i_funct3),
    .reqOff    (reqOff),
    .reqWdata  (i_wdata),
    .memBe     (reqBe),
    .memWdata  (reqWdata),
    .rspFunct3 (funct3Q),
    .rspOff    (offQ),
    .memRdata  (i_mem_rdata),
    .loadData  (loadData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      weQ     <= 1'b0;
      funct3Q <= 3'b000;
      offQ    <= 2'b00;
      addrQ   <= '0;
      beQ     <= 4'b0000;
      wdataQ  <= '0;
      rdataQ  <= '0;
      busErrQ <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalignQ <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            weQ     <= i_we;
            funct3Q <= i_funct3;
            offQ    <= reqOff;
            addrQ   <= i_addr[31:2];
            beQ     <= reqBe;
            wdataQ  <= reqWdata;
            cnt     <= '0;
            rdataQ  <= '0;
            busErrQ <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            misalignQ <= 1'b0;
`endif
            if (!isLegalWidth(i_funct3)) begin
              busErrQ <= 1'b1;
              state   <= RESP;
`ifdef MISALIGN_TRAP_EN
            end else if (misalignReq) begin
              misalignQ <= 1'b1;
              state     <= RESP;
`endif
            end else begin
              state <= ACCESS;
            end
          end
        end
        // An ack on the final timeout cycle still completes the access normally.
        ACCESS: begin
          if (i_mem_ack) begin
            rdataQ <= weQ ? '0 : loadData;
            state  <= RESP;
          end else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            busErrQ <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = (state == IDLE);
  assign o_stall      = ((state == IDLE) && i_req_valid) || (state == ACCESS);
  assign o_resp_valid = (state == RESP);
  assign o_rdata      = rdataQ;
  assign o_bus_err    = busErrQ;
  assign o_mem_req    = (state == ACCESS);
  assign o_mem_we     = weQ;
  assign o_mem_addr   = addrQ;
  assign o_mem_be     = beQ;
  assign o_mem_wdata  = wdataQ;

endmodule

// File: tb/tb_klp32_lsu.sv
// Scoreboard bench for klp32_lsu: a reference model predicts memory traffic and responses.
module tb_klp32_lsu;

  localparam int TIMEOUT = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_we, i_mem_ack;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, i_mem_rdata;
  logic        o_req_ready, o_stall, o_resp_valid, o_bus_err, o_misaligned;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_rdata, o_mem_wdata;
  logic [29:0] o_mem_addr;
  logic [3:0]  o_mem_be;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t expQ[$];

  logic        planNoMem, planNoAck, planWe;
  int          planDelay;
  logic [31:0] planRdata, planWdata;
  logic [29:0] planAddr;
  logic [3:0]  planBe;

  klp32_lsu #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_stall(o_stall), .o_resp_valid(o_resp_valid), .o_rdata(o_rdata),
    .o_bus_err(o_bus_err), .o_misaligned(o_misaligned),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Works byte-by-byte from the access size and address instead of bit slicing.
  function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input int delay, input bit noAck, output exp_t e,
                                output logic noMem, output logic [3:0] be,
                                output logic [31:0] wd);
    int size, off;
    bit legal, sgn;
    longint v, span;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    sgn   = !f3[2];
    e.rdata = 0; e.err = 0; e.mis = 0; e.cyc = 0;
    noMem = 0; be = 0; wd = 0;
    if (!legal) begin
      e.err = 1; noMem = 1;
      return;
    end
    off = int'(addr % 4);
`ifdef MISALIGN_TRAP_EN
    if (off % size != 0) begin
      e.mis = 1; noMem = 1;
      return;
    end
`endif
    off = off - (off % size);
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) be[i] = 1'b1;
      wd[8*i +: 8] = wdata[8*(i % size) +: 8];
    end
    if (noAck) begin
      e.err = 1; e.cyc = TIMEOUT;
      return;
    end
    e.cyc = 1 + delay;
    if (!we) begin
      span = longint'(1) << (8 * size);
      v = (longint'(rdata) >> (8 * off)) % span;
      if (sgn && v >= span / 2) v = v - span;
      e.rdata = v[31:0];
    end
  endfunction

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input int delay, input bit noAck);
    exp_t e;
    logic nm;
    logic [3:0] be;
    logic [31:0] wd;
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(o_req_ready && expQ.size() == 0) && guard < 100);
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL ready_wait: got ready=%0b queued=%0d, required ready=1 queued=0",
               o_req_ready, expQ.size());
    end
    model(we, f3, addr, wdata, rdata, delay, noAck, e, nm, be, wd);
    planNoMem = nm; planNoAck = noAck; planDelay = delay; planRdata = rdata;
    planWe = we; planAddr = addr[31:2]; planBe = be; planWdata = wd;
    e.cyc = cyc + 1 + e.cyc;
    expQ.push_back(e);
    i_req_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    #1 chk("stall_on_request", {31'd0, o_stall}, 32'd1);
    @(negedge clk);
    i_req_valid = 1'b0;
    i_addr = $urandom; i_wdata = $urandom; i_we = 1'($urandom); i_funct3 = 3'($urandom);
  endtask

  // Memory responder: checks the request it sees, then acks after the planned wait.
  initial begin
    int waitCnt = 0;
    i_mem_ack = 1'b0;
    i_mem_rdata = '0;
    forever begin
      @(negedge clk);
      i_mem_ack = 1'b0;
      i_mem_rdata = $urandom;
      if (!rst_n || !o_mem_req) begin
        waitCnt = 0;
      end else begin
        chk("mem_req_expected", {31'd0, planNoMem}, 32'd0);
        chk("mem_addr", {2'b00, o_mem_addr}, {2'b00, planAddr});
        chk("mem_be", {28'd0, o_mem_be}, {28'd0, planBe});
        chk("mem_we", {31'd0, o_mem_we}, {31'd0, planWe});
        if (planWe) chk("mem_wdata", o_mem_wdata, planWdata);
        chk("stall_in_access", {31'd0, o_stall}, 32'd1);
        if (!planNoAck && waitCnt == planDelay) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = planRdata;
        end
        waitCnt++;
      end
    end
  end

  // Response monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && o_resp_valid) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h, required no response", o_rdata);
        end else begin
          e = expQ.pop_front();
          chk("resp_rdata", o_rdata, e.rdata);
          chk("resp_bus_err", {31'd0, o_bus_err}, {31'd0, e.err});
          chk("resp_misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
          chk("resp_cycle", cyc, e.cyc);
          chk("resp_stall", {31'd0, o_stall}, 32'd0);
          chk("resp_ready", {31'd0, o_req_ready}, 32'd0);
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    chk({tag, "_ready"}, {31'd0, o_req_ready}, 32'd1);
    chk({tag, "_mem_req"}, {31'd0, o_mem_req}, 32'd0);
    chk({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
    chk({tag, "_resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_flags"}, {30'd0, o_bus_err, o_misaligned}, 32'd0);
  endtask

  initial begin
    int guard;
    logic [2:0] f3;
    i_req_valid = 0; i_we = 0; i_funct3 = 0; i_addr = 0; i_wdata = 0;
    planNoMem = 1; planNoAck = 0; planDelay = 0; planRdata = 0;
    planWe = 0; planAddr = 0; planBe = 0; planWdata = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1;

    issue(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    issue(1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0);
    issue(0, 3'b000, 32'h103, 32'h0, 32'hA5000000, 1, 0);
    issue(0, 3'b100, 32'h103, 32'h0, 32'hA5000000, 0, 0);
    issue(0, 3'b001, 32'h102, 32'h0, 32'h80010000, 2, 0);
    issue(0, 3'b101, 32'h102, 32'h0, 32'h80010000, 0, 0);
    issue(0, 3'b010, 32'h200, 32'h0, 32'h12345678, 0, 1);
    issue(0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 0, 0);
    issue(0, 3'b010, 32'h204, 32'h0, 32'h0BADF00D, TIMEOUT - 1, 0);
    issue(0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0, 0);
    issue(1, 3'b001, 32'h10F, 32'h0000BEEF, 32'h0, 1, 0);
    issue(0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
    issue(1, 3'b111, 32'h100, 32'h55, 32'h0, 0, 0);

    // Reset in the middle of an access that will never be acknowledged.
    issue(0, 3'b010, 32'h300, 32'h0, 32'h0, 0, 1);
    @(negedge clk);
    rst_n = 0;
    #1 checkResetOutputs("async_reset");
    expQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 5));
      issue(1'($urandom), f3, {22'd0, 10'($urandom)}, $urandom, $urandom,
            $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 9) == 0);
    end

    guard = 0;
    while (expQ.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (expQ.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d responses outstanding, required 0", expQ.size());
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
